// File: rtl/vector_register_file.sv
// Vector register file: NUM_REGS x VLEN, two registered read ports, one
// byte-enabled write port with same-cycle bypass, and a sequential bulk clear.
module vector_register_file #(
    parameter int NUM_REGS   = 32,
    parameter int VLEN       = 128,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    localparam int BE_WIDTH  = VLEN / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [VLEN-1:0]       rd0_data,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [VLEN-1:0]       rd1_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [VLEN-1:0]       wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [VLEN-1:0]       mem [NUM_REGS];

    logic                  eff_we;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [VLEN-1:0]       eff_data;
    logic [BE_WIDTH-1:0]   eff_be;
    logic [VLEN-1:0]       wr_mask;
    logic [VLEN-1:0]       wr_merged;
    logic [VLEN-1:0]       rd0_next;
    logic [VLEN-1:0]       rd1_next;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // The clear engine owns the write port while clearing
    always_comb begin
        eff_we   = 1'b0;
        eff_addr = wr_addr;
        eff_data = wr_data;
        eff_be   = wr_be;
        if (state == S_CLEAR) begin
            eff_we   = 1'b1;
            eff_addr = cnt;
            eff_data = '0;
            eff_be   = '1;
        end else if (wr_en && in_range(wr_addr)) begin
            eff_we = 1'b1;
        end
    end

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            wr_mask[8*i +: 8] = {8{eff_be[i]}};
        end
    end

    assign wr_merged = (mem[eff_addr] & ~wr_mask) | (eff_data & wr_mask);

    always_comb begin
        rd0_next = '0;
        rd1_next = '0;
        if (in_range(rd0_addr)) begin
            rd0_next = (eff_we && eff_addr == rd0_addr) ? wr_merged : mem[rd0_addr];
        end
        if (in_range(rd1_addr)) begin
            rd1_next = (eff_we && eff_addr == rd1_addr) ? wr_merged : mem[rd1_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (eff_we) begin
            mem[eff_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0_data <= '0;
            rd1_data <= '0;
        end else begin
            if (rd0_en) rd0_data <= rd0_next;
            if (rd1_en) rd1_data <= rd1_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= S_CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (int'(cnt) == NUM_REGS - 1) begin
                        state    <= S_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_register_file.sv
// Randomised bench for vector_register_file against a byte-level
// reference model where reads observe the same cycle's write.
module tb_vector_register_file;

    localparam int NR = 32;
    localparam int VL = 128;
    localparam int BW = VL / 8;
    localparam int AW = $clog2(NR);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          rd0_en, rd1_en, wr_en, clr_req;
    logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
    logic [VL-1:0] rd0_data, rd1_data, wr_data;
    logic [BW-1:0] wr_be;
    logic          clr_busy, clr_done;

    vector_register_file dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd0_en  (rd0_en),
        .rd0_addr(rd0_addr),
        .rd0_data(rd0_data),
        .rd1_en  (rd1_en),
        .rd1_addr(rd1_addr),
        .rd1_data(rd1_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [VL-1:0] ref_mem [NR];
    logic [VL-1:0] exp_rd0, exp_rd1;
    int            phase;
    int            clr_idx;
    int            busy_n, done_n;

    task automatic check(input string tag, input logic [VL-1:0] got,
                         input logic [VL-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        phase   = 0;
        clr_idx = 0;
    endtask

    // phase: 0 idle, 1 clearing, 2 done pulse
    task automatic model_tick();
        if (phase == 1) begin
            ref_mem[clr_idx] = '0;
        end else if (wr_en && int'(wr_addr) < NR) begin
            for (int i = 0; i < BW; i++) begin
                if (wr_be[i]) ref_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        if (rd0_en) exp_rd0 = (int'(rd0_addr) < NR) ? ref_mem[rd0_addr] : '0;
        if (rd1_en) exp_rd1 = (int'(rd1_addr) < NR) ? ref_mem[rd1_addr] : '0;
        if (phase == 0) begin
            if (clr_req) begin
                phase   = 1;
                clr_idx = 0;
            end
        end else if (phase == 1) begin
            if (clr_idx == NR - 1) phase = 2;
            else clr_idx++;
        end else begin
            phase = 0;
        end
    endtask

    task automatic quiet();
        rd0_en = 0; rd1_en = 0; wr_en = 0; clr_req = 0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0;
        wr_data = '0; wr_be = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_tick();
        check("rd0", rd0_data, exp_rd0);
        check("rd1", rd1_data, exp_rd1);
        check("busy", VL'(clr_busy), VL'(phase == 1));
        check("done", VL'(clr_done), VL'(phase == 2));
    endtask

    task automatic write(input int a, input logic [VL-1:0] d,
                         input logic [BW-1:0] be);
        quiet();
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        cyc();
    endtask

    task automatic run_clear(input int wr_at, input string tag);
        quiet();
        clr_req = 1;
        cyc();
        clr_req = 0;
        busy_n = int'(clr_busy);
        done_n = int'(clr_done);
        for (int n = 0; n < 40; n++) begin
            quiet();
            if (n == wr_at) begin
                wr_en = 1; wr_addr = 3; wr_data = '1; wr_be = '1;
            end
            cyc();
            busy_n += int'(clr_busy);
            done_n += int'(clr_done);
        end
        check({tag, "_busy_cycles"}, VL'(busy_n), VL'(NR));
        check({tag, "_done_pulses"}, VL'(done_n), VL'(1));
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < NR; i++) begin
            quiet();
            rd0_en = 1; rd0_addr = AW'(i);
            rd1_en = 1; rd1_addr = AW'(NR - 1 - i);
            cyc();
            check({tag, "_rd0"}, rd0_data, '0);
            check({tag, "_rd1"}, rd1_data, '0);
        end
    endtask

    initial begin
        quiet();
        model_reset();
        #2 reset_n = 0;
        #1;
        check("rst_rd0", rd0_data, '0);
        check("rst_rd1", rd1_data, '0);
        check("rst_busy", VL'(clr_busy), '0);
        check("rst_done", VL'(clr_done), '0);
        @(negedge clk) reset_n = 1;

        read_all_zero("t1");

        write(5, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01, '1);
        quiet(); rd0_en = 1; rd0_addr = 5;
        cyc();
        check("t2_r5", rd0_data, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01);

        write(5, '1, 16'h000F);
        quiet(); rd0_en = 1; rd0_addr = 5;
        cyc();
        check("t3_r5", rd0_data, 128'hDEADBEEF_CAFEF00D_12345678_FFFFFFFF);

        quiet();
        wr_en = 1; wr_addr = 7; wr_data = {16{8'hA5}}; wr_be = 16'h00FF;
        rd1_en = 1; rd1_addr = 7;
        cyc();
        check("t4_bypass", rd1_data, 128'h0000_0000_0000_0000_A5A5_A5A5_A5A5_A5A5);
        quiet(); rd0_en = 1; rd0_addr = 7;
        cyc();
        check("t4_array", rd0_data, 128'h0000_0000_0000_0000_A5A5_A5A5_A5A5_A5A5);

        for (int i = 0; i < NR; i++) begin
            write(i, {$urandom, $urandom, $urandom, $urandom}, '1);
        end
        run_clear(5, "t5");
        read_all_zero("t5_after");

        write(0, 128'h1111, '1);
        write(1, 128'h2222, '1);
        quiet(); clr_req = 1;
        cyc();
        repeat (10) begin
            quiet();
            cyc();
        end
        #2 reset_n = 0;
        #1;
        check("t6_rd0", rd0_data, '0);
        check("t6_rd1", rd1_data, '0);
        check("t6_busy", VL'(clr_busy), '0);
        check("t6_done", VL'(clr_done), '0);
        model_reset();
        @(negedge clk) reset_n = 1;
        repeat (3) begin
            quiet();
            cyc();
        end
        write(0, 128'h1111, '1);
        write(1, 128'h2222, '1);
        quiet(); clr_req = 1; rd0_en = 1; rd0_addr = 0;
        cyc();
        check("t6_r0_pre", rd0_data, 128'h1111);
        quiet(); rd0_en = 1; rd0_addr = 0; rd1_en = 1; rd1_addr = 1;
        cyc();
        check("t6_r0_cnt0", rd0_data, '0);
        check("t6_r1_kept", rd1_data, 128'h2222);
        repeat (NR + 2) begin
            quiet();
            cyc();
        end

        for (int n = 0; n < 3000; n++) begin
            rd0_en   = 1'($urandom);
            rd1_en   = 1'($urandom);
            rd0_addr = AW'($urandom_range(0, NR - 1));
            rd1_addr = ($urandom_range(0, 3) == 0) ? rd0_addr
                                                   : AW'($urandom_range(0, NR - 1));
            wr_en    = 1'($urandom);
            wr_addr  = ($urandom_range(0, 2) == 0) ? rd0_addr
                                                   : AW'($urandom_range(0, NR - 1));
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            wr_be    = BW'($urandom);
            clr_req  = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
